// File: rtl/dmem_mmio_responder.sv
// Memory-mapped I/O responder beside dmem: TX word FIFO, one-word RX holding register, optional cycle counter.
// Define MMIO_CYCLE_COUNTER_EN to build the 32-bit cycle counter at offset 3; otherwise offset 3 reads 0.
module dmem_mmio_responder #(
  parameter logic [11:0] BASE_ADDR  = 12'hFF0,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [11:0]       address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_mmio,
  output logic              mmio_sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_reg_q, rx_reg_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              sel_q, sel_d;
`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0]       cycle_q, cycle_d;
`endif

  logic              hit;
  logic [3:0]        offset;
  logic              full, empty;
  logic              push, pop, push_req;
  logic              capture, rx_pop;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] cycle_rd;

  // Decode, FIFO/RX control and read mux; every read sees pre-edge register values.
  always_comb begin
    hit      = (address_dmem[11:4] == BASE_ADDR[11:4]);
    offset   = address_dmem[3:0];
    full     = (count_q == CW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    pop      = ~empty & out_ready;
    push_req = hit & wren & (offset == 4'd0);
    push     = push_req & (~full | pop);
    capture  = in_valid & ~rx_valid_q;
    rx_pop   = hit & ~wren & (offset == 4'd2);

    status      = '0;
    status[31]  = rx_valid_q;
    status[30]  = ovf_q;
    status[8]   = full;
    status[7]   = empty;
    status[4:0] = 5'(count_q);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    // Set beats clear when both happen on one edge.
    ovf_d = ovf_q;
    if (hit & wren & (offset == 4'd1) & data[30]) ovf_d = 1'b0;
    if (push_req & full & ~pop)                   ovf_d = 1'b1;

    // A capture outranks a pop so an arriving word is never lost.
    rx_valid_d = capture ? 1'b1 : (rx_pop ? 1'b0 : rx_valid_q);
    rx_reg_d   = capture ? in_data : rx_reg_q;

`ifdef MMIO_CYCLE_COUNTER_EN
    cycle_rd = DATA_W'(cycle_q);
    cycle_d  = (hit & wren & (offset == 4'd3)) ? data[31:0] : cycle_q + 32'd1;
`else
    cycle_rd = '0;
`endif

    q_d   = '0;
    sel_d = hit;
    if (hit) begin
      case (offset)
        4'd1:    q_d = status;
        4'd2:    q_d = rx_reg_q;
        4'd3:    q_d = cycle_rd;
        default: q_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_reg_q   <= '0;
      q_q        <= '0;
      sel_q      <= 1'b0;
`ifdef MMIO_CYCLE_COUNTER_EN
      cycle_q    <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rx_valid_q <= rx_valid_d;
      rx_reg_q   <= rx_reg_d;
      q_q        <= q_d;
      sel_q      <= sel_d;
`ifdef MMIO_CYCLE_COUNTER_EN
      cycle_q    <= cycle_d;
`endif
    end
  end

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clock) begin
    if (reset && push) mem[wr_ptr_q] <= data;
  end

  assign q_mmio    = q_q;
  assign mmio_sel  = sel_q;
  assign out_data  = mem[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign in_ready  = ~rx_valid_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed self-checking bench for dmem_mmio_responder (default 8-deep FIFO, window FF0..FFF).
// Honours MMIO_CYCLE_COUNTER_EN for the offset-3 expectations.
module tb_dmem_mmio_responder;

  logic        clock;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_mmio;
  logic        mmio_sel;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  int checks = 0;
  int errors = 0;

  dmem_mmio_responder dut (
    .clock       (clock),
    .reset       (reset),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .q_mmio      (q_mmio),
    .mmio_sel    (mmio_sel),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One bus cycle at addr, then the bus returns to an idle out-of-window address.
  task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] wdata, input logic we);
    address_dmem = addr;
    data         = wdata;
    wren         = we;
    tick();
    address_dmem = 12'h000;
    data         = 32'h0;
    wren         = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [31:0] expHead;

    reset        = 1'b0;
    address_dmem = 12'h000;
    data         = 32'h0;
    wren         = 1'b0;
    out_ready    = 1'b0;
    in_data      = 32'h0;
    in_valid     = 1'b0;

    tick();
    tick();
    checkOutput("rst_q", q_mmio, 32'h0);
    checkOutput("rst_sel", {31'b0, mmio_sel}, 32'h0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);
    reset = 1'b1;

    applyStimulus(12'hFF1, 32'h0, 1'b0);
    checkOutput("status_empty", q_mmio, 32'h0000_0080);
    checkOutput("status_sel", {31'b0, mmio_sel}, 32'h1);

    // Three pushes with the consumer stalled, then drain in order.
    applyStimulus(12'hFF0, 32'd1, 1'b1);
    checkOutput("txdata_q", q_mmio, 32'h0);
    checkOutput("txdata_sel", {31'b0, mmio_sel}, 32'h1);
    checkOutput("head_first", out_data, 32'd1);
    applyStimulus(12'hFF0, 32'd2, 1'b1);
    applyStimulus(12'hFF0, 32'd3, 1'b1);
    applyStimulus(12'hFF1, 32'h0, 1'b0);
    checkOutput("status_count3", q_mmio, 32'h0000_0003);
    out_ready = 1'b1;
    checkOutput("drain_0", out_data, 32'd1);
    tick();
    checkOutput("drain_1", out_data, 32'd2);
    tick();
    checkOutput("drain_2", out_data, 32'd3);
    tick();
    checkOutput("drain_empty", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b0;

    // Nine pushes into eight entries: the last one is dropped and flags overflow.
    for (int i = 0; i < 9; i++) applyStimulus(12'hFF0, 32'h10 + i, 1'b1);
    applyStimulus(12'hFF1, 32'h0, 1'b0);
    checkOutput("status_ovf_full", q_mmio, 32'h4000_0108);
    applyStimulus(12'hFF1, 32'h4000_0000, 1'b1);
    checkOutput("status_wr_preedge", q_mmio, 32'h4000_0108);
    applyStimulus(12'hFF1, 32'h0, 1'b0);
    checkOutput("status_ovf_clr", q_mmio, 32'h0000_0108);

    out_ready = 1'b1;
    applyStimulus(12'hFF0, 32'h99, 1'b1);
    out_ready = 1'b0;
    checkOutput("full_pushpop_head", out_data, 32'h11);
    applyStimulus(12'hFF1, 32'h0, 1'b0);
    checkOutput("full_pushpop_status", q_mmio, 32'h0000_0108);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expHead = (i < 7) ? 32'h11 + i : 32'h99;
      checkOutput($sformatf("order_%0d", i), out_data, expHead);
      tick();
    end
    checkOutput("order_empty", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b0;

    // RX capture, pop via RXDATA read, and a held second word.
    in_data  = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    tick();
    checkOutput("rx_in_ready_low", {31'b0, in_ready}, 32'h0);
    in_data = 32'hCAFE_F00D;
    applyStimulus(12'hFF2, 32'h0, 1'b0);
    checkOutput("rx_read1", q_mmio, 32'hDEAD_BEEF);
    checkOutput("rx_in_ready_back", {31'b0, in_ready}, 32'h1);
    applyStimulus(12'hFF1, 32'h0, 1'b0);
    checkOutput("rx_status_preedge", q_mmio, 32'h0000_0080);
    checkOutput("rx_second_captured", {31'b0, in_ready}, 32'h0);
    in_valid = 1'b0;
    applyStimulus(12'hFF2, 32'h0, 1'b0);
    checkOutput("rx_read2", q_mmio, 32'hCAFE_F00D);
    applyStimulus(12'hFF1, 32'h0, 1'b0);
    checkOutput("rx_status_clear", q_mmio, 32'h0000_0080);
    checkOutput("rx_in_ready_idle", {31'b0, in_ready}, 32'h1);

    // Unused offset and out-of-window decode.
    applyStimulus(12'hFF7, 32'h0, 1'b0);
    checkOutput("ff7_q", q_mmio, 32'h0);
    checkOutput("ff7_sel", {31'b0, mmio_sel}, 32'h1);
    applyStimulus(12'h100, 32'h0, 1'b0);
    checkOutput("miss_sel", {31'b0, mmio_sel}, 32'h0);
    checkOutput("miss_q", q_mmio, 32'h0);

`ifdef MMIO_CYCLE_COUNTER_EN
    // Load lands at the write edge; the idle edge after it increments to FFFF_FFFF.
    applyStimulus(12'hFF3, 32'hFFFF_FFFE, 1'b1);
    tick();
    applyStimulus(12'hFF3, 32'h0, 1'b0);
    checkOutput("cycle_max", q_mmio, 32'hFFFF_FFFF);
    applyStimulus(12'hFF3, 32'h0, 1'b0);
    checkOutput("cycle_wrap", q_mmio, 32'h0000_0000);
    applyStimulus(12'hFF3, 32'h0, 1'b0);
    checkOutput("cycle_after_wrap", q_mmio, 32'h0000_0001);
`else
    applyStimulus(12'hFF3, 32'hFFFF_FFFE, 1'b1);
    checkOutput("cycle_wr_q", q_mmio, 32'h0);
    applyStimulus(12'hFF3, 32'h0, 1'b0);
    checkOutput("cycle_absent", q_mmio, 32'h0);
    checkOutput("cycle_absent_sel", {31'b0, mmio_sel}, 32'h1);
`endif

    // Reset in the middle of activity: FIFO holds words, RX holds a word, consumer ready.
    applyStimulus(12'hFF0, 32'hAA, 1'b1);
    applyStimulus(12'hFF0, 32'hBB, 1'b1);
    in_data  = 32'h0000_1234;
    in_valid = 1'b1;
    tick();
    checkOutput("pre_rst_rx", {31'b0, in_ready}, 32'h0);
    reset        = 1'b0;
    out_ready    = 1'b1;
    address_dmem = 12'hFF1;
    tick();
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("midrst_q", q_mmio, 32'h0);
    checkOutput("midrst_sel", {31'b0, mmio_sel}, 32'h0);
    reset        = 1'b1;
    out_ready    = 1'b0;
    in_valid     = 1'b0;
    address_dmem = 12'h000;
    applyStimulus(12'hFF1, 32'h0, 1'b0);
    checkOutput("postrst_status", q_mmio, 32'h0000_0080);
    applyStimulus(12'hFF2, 32'h0, 1'b0);
    checkOutput("postrst_rxreg", q_mmio, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
